whack_round_ctrl: RTL and testbench

Round sequencer for the whack-a-mole game. Owns one down-counting interval timer and drives its reload, interval and direction inputs. Lights one mole per round, judges button presses against the timer timeout, and keeps score and miss count. Shortens the interval as the game progresses and stops the game after a fixed number of rounds or misses.

---
 rtl/whack_round_ctrl_if.sv | 11 +
 rtl/whack_round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_whack_round_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/whack_round_ctrl_if.sv
// Timer-side link of the whack-a-mole round sequencer.
// The controller (master) drives reload/interval/direction; the timer (slave) returns timeout.
interface whack_round_ctrl_if;
    logic       tmr_rst_n;
    logic [2:0] tmr_interval;
    logic       tmr_dir;
    logic       tmr_timeout;

    modport master (output tmr_rst_n, output tmr_interval, output tmr_dir, input tmr_timeout);
    modport slave  (input tmr_rst_n, input tmr_interval, input tmr_dir, output tmr_timeout);
endinterface

// File: rtl/whack_round_ctrl.sv
// Whack-a-mole round sequencer: lights one mole per round, judges presses against the timer.
// Optional feature: define WHACK_NO_REPEAT_EN to forbid the same hole in consecutive rounds.
module whack_round_ctrl #(
    parameter int NUM_MOLES      = 4,
    parameter int ROUNDS         = 16,
    parameter int MAX_MISSES     = 3,
    parameter int START_INTERVAL = 5,
    parameter int MIN_INTERVAL   = 1,
    parameter int SPEEDUP_EVERY  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MOLES-1:0] btn,
    whack_round_ctrl_if.master   tmr,
    output logic [NUM_MOLES-1:0] mole,
    output logic [7:0]           score,
    output logic [3:0]           misses,
    output logic [4:0]           round,
    output logic                 busy,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(NUM_MOLES);

    typedef enum logic [2:0] {IDLE, ARM, WAIT, JUDGE, NEXT, DONE} state_t;

    state_t               state_reg, state_next;
    logic [7:0]           lfsr_reg, lfsr_next;
    logic [NUM_MOLES-1:0] mole_reg, mole_next;
    logic [7:0]           score_reg, score_next;
    logic [3:0]           misses_reg, misses_next;
    logic [4:0]           round_reg, round_next;
    logic [2:0]           interval_reg, interval_next;
    logic                 busy_reg, busy_next;
    logic                 game_over_reg, game_over_next;
    logic                 tmr_rst_n_reg, tmr_rst_n_next;

    logic [IDX_W-1:0]     idx_raw;
    logic [IDX_W-1:0]     idx_sel;
    logic [NUM_MOLES-1:0] idx_onehot;

    assign idx_raw = lfsr_reg[IDX_W-1:0];

`ifdef WHACK_NO_REPEAT_EN
    logic [IDX_W-1:0] prev_idx_reg;

    // Bump to the neighbouring hole when the LFSR repeats last round's pick.
    assign idx_sel = (idx_raw == prev_idx_reg) ? idx_raw + IDX_W'(1) : idx_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_idx_reg <= '0;
        end else if (state_reg == ARM) begin
            prev_idx_reg <= idx_sel;
        end
    end
`else
    assign idx_sel = idx_raw;
`endif

    generate
        for (genvar gi = 0; gi < NUM_MOLES; gi++) begin : g_onehot
            assign idx_onehot[gi] = (idx_sel == IDX_W'(gi));
        end
    endgenerate

    // Galois LFSR, taps 0xB8, free-running in every state.
    assign lfsr_next = {1'b0, lfsr_reg[7:1]} ^ (lfsr_reg[0] ? 8'hB8 : 8'h00);

    always_comb begin
        state_next     = state_reg;
        mole_next      = mole_reg;
        score_next     = score_reg;
        misses_next    = misses_reg;
        round_next     = round_reg;
        interval_next  = interval_reg;
        busy_next      = busy_reg;
        game_over_next = game_over_reg;
        tmr_rst_n_next = tmr_rst_n_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next     = ARM;
                    score_next     = '0;
                    misses_next    = '0;
                    round_next     = '0;
                    interval_next  = 3'(START_INTERVAL);
                    busy_next      = 1'b1;
                    game_over_next = 1'b0;
                end
            end
            ARM: begin
                state_next     = WAIT;
                mole_next      = idx_onehot;
                tmr_rst_n_next = 1'b1;
            end
            WAIT: begin
                // A press in the timeout cycle takes precedence over the timeout.
                if (btn != '0) begin
                    state_next     = JUDGE;
                    mole_next      = '0;
                    tmr_rst_n_next = 1'b0;
                    if (btn == mole_reg) begin
                        score_next = (score_reg != 8'hFF) ? score_reg + 8'd1 : score_reg;
                    end else begin
                        misses_next = misses_reg + 4'd1;
                    end
                end else if (tmr.tmr_timeout) begin
                    state_next     = JUDGE;
                    mole_next      = '0;
                    tmr_rst_n_next = 1'b0;
                    misses_next    = misses_reg + 4'd1;
                end
            end
            JUDGE: begin
                state_next = NEXT;
                round_next = round_reg + 5'd1;
            end
            NEXT: begin
                if (round_reg == 5'(ROUNDS) || misses_reg == 4'(MAX_MISSES)) begin
                    state_next     = DONE;
                    busy_next      = 1'b0;
                    game_over_next = 1'b1;
                end else begin
                    state_next = ARM;
                    if ((int'(round_reg) % SPEEDUP_EVERY) == 0 &&
                        interval_reg > 3'(MIN_INTERVAL)) begin
                        interval_next = interval_reg - 3'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            lfsr_reg      <= 8'hA5;
            mole_reg      <= '0;
            score_reg     <= '0;
            misses_reg    <= '0;
            round_reg     <= '0;
            interval_reg  <= 3'(START_INTERVAL);
            busy_reg      <= 1'b0;
            game_over_reg <= 1'b0;
            tmr_rst_n_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lfsr_reg      <= lfsr_next;
            mole_reg      <= mole_next;
            score_reg     <= score_next;
            misses_reg    <= misses_next;
            round_reg     <= round_next;
            interval_reg  <= interval_next;
            busy_reg      <= busy_next;
            game_over_reg <= game_over_next;
            tmr_rst_n_reg <= tmr_rst_n_next;
        end
    end

    assign tmr.tmr_rst_n    = tmr_rst_n_reg;
    assign tmr.tmr_interval = interval_reg;
    assign tmr.tmr_dir      = 1'b0;
    assign mole             = mole_reg;
    assign score            = score_reg;
    assign misses           = misses_reg;
    assign round            = round_reg;
    assign busy             = busy_reg;
    assign game_over        = game_over_reg;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Directed bench for whack_round_ctrl: hits, misses, timeouts, speedup, game end, reset.
// Define WHACK_NO_REPEAT_EN to also exercise the no-repeat hole selection.
module tb_whack_round_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] btn = '0;
    logic [3:0] mole;
    logic [7:0] score;
    logic [3:0] misses;
    logic [4:0] round;
    logic       busy;
    logic       game_over;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] lfsr_m;
    logic [1:0] prev_m = 2'd0;
    logic [3:0] exp_mole;
    logic [3:0] last_mole;

    whack_round_ctrl_if tmr_if();

    whack_round_ctrl #(
        .NUM_MOLES(4), .ROUNDS(16), .MAX_MISSES(3),
        .START_INTERVAL(5), .MIN_INTERVAL(3), .SPEEDUP_EVERY(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .tmr(tmr_if),
        .mole(mole), .score(score), .misses(misses), .round(round),
        .busy(busy), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 8-bit Galois, taps 0xB8, seed 0xA5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 8'hA5;
        else        lfsr_m <= lfsr_m[0] ? ((lfsr_m >> 1) ^ 8'hB8) : (lfsr_m >> 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tmr_rst_n"}, tmr_if.tmr_rst_n, 0);
        chk({tag, "_interval"},  tmr_if.tmr_interval, 5);
        chk({tag, "_dir"},       tmr_if.tmr_dir, 0);
        chk({tag, "_mole"},      mole, 0);
        chk({tag, "_score"},     score, 0);
        chk({tag, "_misses"},    misses, 0);
        chk({tag, "_round"},     round, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_game_over"}, game_over, 0);
    endtask

    // Pulse start from IDLE/DONE; returns in ARM.
    task automatic do_start;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_game_over", game_over, 0);
        chk("start_interval", tmr_if.tmr_interval, 5);
        chk("start_tmr_rst_n", tmr_if.tmr_rst_n, 0);
        chk("start_score", score, 0);
        chk("start_misses", misses, 0);
        chk("start_round", round, 0);
    endtask

    // Called in ARM: predict the hole, advance into WAIT and check it.
    task automatic enter_wait;
        logic [1:0] eidx;
        eidx = lfsr_m[1:0];
`ifdef WHACK_NO_REPEAT_EN
        if (eidx == prev_m) eidx = eidx + 2'd1;
        prev_m = eidx;
`endif
        exp_mole = 4'b0001 << eidx;
        tick();
        chk("wait_mole", mole, exp_mole);
        chk("wait_tmr_rst_n", tmr_if.tmr_rst_n, 1);
    endtask

    // Called in WAIT: present btn/timeout for one cycle; returns in JUDGE.
    task automatic act(input logic [3:0] b, input logic to);
        btn = b;
        tmr_if.tmr_timeout = to;
        tick();
        btn = '0;
        tmr_if.tmr_timeout = 1'b0;
        $display("txn btn=%b timeout=%0d mole_exp=%b score=%0d misses=%0d", b, to, exp_mole, score, misses);
        chk("judge_mole", mole, 0);
        chk("judge_tmr_rst_n", tmr_if.tmr_rst_n, 0);
    endtask

    initial begin
        tmr_if.tmr_timeout = 1'b0;

        // Reset values while held in reset.
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("idle");

        // ---- Game 1: hit, wrong, multi, simultaneous, timeout to game over ----
        do_start();
        chk("arm_mole", mole, 0);
        enter_wait();
        act(exp_mole, 1'b0);
        chk("hit_score", score, 1);
        chk("hit_misses", misses, 0);
        tick();
        chk("next_round1", round, 1);
        tick();
        chk("arm_tmr_rst_n", tmr_if.tmr_rst_n, 0);
        chk("arm_busy", busy, 1);
        enter_wait();

        act({exp_mole[2:0], exp_mole[3]}, 1'b0);
        chk("wrong_misses", misses, 1);
        chk("wrong_score", score, 1);
        tick();
        tick();
        enter_wait();

        act(exp_mole | {exp_mole[2:0], exp_mole[3]}, 1'b0);
        chk("multi_misses", misses, 2);
        tick();
        tick();
        enter_wait();

        act(exp_mole, 1'b1);
        chk("simul_score", score, 2);
        chk("simul_misses", misses, 2);
        tick();
        chk("next_round4", round, 4);
        tick();
        chk("speedup_r4_interval", tmr_if.tmr_interval, 4);
        enter_wait();

        act(4'b0000, 1'b1);
        chk("timeout_misses", misses, 3);
        tick();
        tick();
        chk("done_game_over", game_over, 1);
        chk("done_busy", busy, 0);
        chk("done_score", score, 2);
        chk("done_round", round, 5);
        chk("done_mole", mole, 0);
        chk("done_tmr_rst_n", tmr_if.tmr_rst_n, 0);
        btn = 4'b1111;
        tmr_if.tmr_timeout = 1'b1;
        tick();
        tick();
        btn = '0;
        tmr_if.tmr_timeout = 1'b0;
        chk("done_hold_misses", misses, 3);
        chk("done_hold_score", score, 2);
        chk("done_hold_game_over", game_over, 1);

        // ---- Game 2: restart from DONE, 16 hits with speedup and floor ----
        do_start();
        for (int r = 1; r <= 16; r++) begin
            enter_wait();
            for (int k = 0; k < (r % 3); k++) begin
                tick();
                chk("wait_hold_mole", mole, exp_mole);
            end
            act(exp_mole, 1'b0);
            chk("g2_score", score, r);
            tick();
            chk("g2_round", round, r);
            tick();
            if (r < 16) begin
                chk("g2_interval", tmr_if.tmr_interval, (r < 4) ? 5 : (r < 8) ? 4 : 3);
                chk("g2_busy", busy, 1);
            end
        end
        chk("g2_game_over", game_over, 1);
        chk("g2_busy_end", busy, 0);
        chk("g2_score_end", score, 16);
        chk("g2_round_end", round, 16);
        chk("g2_misses_end", misses, 0);

`ifdef WHACK_NO_REPEAT_EN
        // ---- No-repeat: 13 games of 16 hits (208 rounds) ----
        last_mole = exp_mole;
        for (int g = 0; g < 13; g++) begin
            do_start();
            for (int r = 0; r < 16; r++) begin
                enter_wait();
                chk("norepeat", (mole != last_mole) ? 1 : 0, 1);
                last_mole = mole;
                act(exp_mole, 1'b0);
                tick();
                tick();
            end
        end
`else
        last_mole = '0;
`endif

        // ---- Mid-game asynchronous reset during WAIT ----
        do_start();
        enter_wait();
        #2;
        rst_n = 1'b0;
        prev_m = 2'd0;
        #1;
        chk_reset_vals("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_rst");
        do_start();
        enter_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
